// File: rtl/send_pkg.sv
// send_pkg: protocol constants shared by the UART transmit packer and the
// matching byte receiver.
//   Protocol byte layout: [7:6]=0, [5:2]=payload, [1:0]=type.
//   Contents: type codes, START/STOP game bytes, the operation-byte
//   encoder and the transmit FSM state type.
package send_pkg;

  localparam int NUM_OPS = 5;

  localparam logic [1:0] TYPE_GAME     = 2'b00;
  localparam logic [1:0] TYPE_OPERATE  = 2'b01;
  localparam logic [1:0] TYPE_FEEDBACK = 2'b10;  // only ever received
  localparam logic [1:0] TYPE_RESERVED = 2'b11;

  localparam logic [3:0] PAYLOAD_START = 4'b0001;
  localparam logic [3:0] PAYLOAD_STOP  = 4'b0010;

  localparam logic [7:0] BYTE_START = {2'b00, PAYLOAD_START, TYPE_GAME};  // 8'h04
  localparam logic [7:0] BYTE_STOP  = {2'b00, PAYLOAD_STOP,  TYPE_GAME};  // 8'h08

  // Operation button idx (0 get .. 4 throw) carries payload idx+1.
  function automatic logic [7:0] op_byte(input int idx);
    logic [3:0] payload;
    payload = 4'(idx + 1);
    return {2'b00, payload, TYPE_OPERATE};
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } send_state_t;

endpackage

// File: rtl/send_byte_fifo.sv
// send_byte_fifo: DEPTH x 8 synchronous show-ahead FIFO.
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en/wr_data : push a byte (accepted when not full, or when full and a
//                   pop happens in the same cycle)
//   rd_en         : pop the head (ignored when empty)
//   rd_data       : current head, valid whenever empty=0
//   full, empty   : status flags derived from the registered count
//   count         : number of stored bytes, 0..DEPTH
module send_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;

  // A pop frees the slot the same-cycle write lands in, so write-on-full
  // is legal whenever a pop accompanies it.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Show-ahead: head is visible without a read request.
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/send_operate_data.sv
// send_operate_data: turns button / game-switch edges into protocol bytes and
// hands them to the UART transmitter one at a time with an idle gap.
//   uart_clk   : sole clock
//   rst        : asynchronous active-high reset
//   btn[4:0]   : debounced buttons (get, put, interact, move, throw)
//   sw_start   : game-run switch level
//   tx_ready   : transmitter accepts a byte this cycle
//   tx_data    : byte offered to the transmitter (registered)
//   tx_valid   : tx_data valid (registered)
//   queue_full : event FIFO full
//   busy_led   : FIFO non-empty or transmit FSM not idle
module send_operate_data
  import send_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic         uart_clk,
  input  logic         rst,
  input  logic [4:0]   btn,
  input  logic         sw_start,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         queue_full,
  output logic         busy_led
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [NUM_OPS-1:0] btn_q_reg;
  logic [NUM_OPS-1:0] rise;
  logic [NUM_OPS-1:0] pend_op_reg, pend_op_next;
  logic [NUM_OPS-1:0] op_clear;
  logic               sw_q_reg;
  logic               sw_rise, sw_fall;
  logic               pend_start_reg, pend_start_next;
  logic               pend_stop_reg, pend_stop_next;
  logic               start_clear, stop_clear;
  logic               have_pending;

  logic               wr_en;
  logic [7:0]         wr_data;
  logic               pop;
  logic [7:0]         fifo_head;
  logic               fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  send_state_t        state_reg, state_next;
  logic [CW-1:0]      gap_cnt_reg, gap_cnt_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic               tx_valid_reg, tx_valid_next;

  // Edge detection
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_edge
    assign rise[gi] = btn[gi] & ~btn_q_reg[gi];
  end

  assign sw_rise = sw_start & ~sw_q_reg;
  assign sw_fall = ~sw_start & sw_q_reg;

  // Pick the single event to enqueue: game start/stop before operations,
  // then the lowest-numbered pending button.
  always_comb begin
    wr_data      = 8'h00;
    op_clear     = '0;
    start_clear  = 1'b0;
    stop_clear   = 1'b0;
    have_pending = pend_start_reg | pend_stop_reg | (|pend_op_reg);
    if (pend_start_reg) begin
      wr_data     = BYTE_START;
      start_clear = 1'b1;
    end else if (pend_stop_reg) begin
      wr_data    = BYTE_STOP;
      stop_clear = 1'b1;
    end else begin
      for (int i = NUM_OPS - 1; i >= 0; i--) begin
        if (pend_op_reg[i]) begin
          wr_data     = op_byte(i);
          op_clear    = '0;
          op_clear[i] = 1'b1;
        end
      end
    end
  end

  assign wr_en = have_pending & (~fifo_full | pop);

  // A pending bit is held while the FIFO cannot take it; a fresh rise on a
  // bit already pending merges into it.
  always_comb begin
    pend_op_next    = (pend_op_reg & ~(wr_en ? op_clear : '0)) | rise;
    pend_start_next = pend_start_reg & ~(wr_en & start_clear);
    pend_stop_next  = pend_stop_reg & ~(wr_en & stop_clear);
    // Start and stop cancel each other so only the latest switch edge survives.
    if (sw_rise) begin
      pend_start_next = 1'b1;
      pend_stop_next  = 1'b0;
    end else if (sw_fall) begin
      pend_stop_next  = 1'b1;
      pend_start_next = 1'b0;
    end
  end

  send_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (uart_clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Transmit FSM
  always_comb begin
    state_next    = state_reg;
    gap_cnt_next  = gap_cnt_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    pop           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          tx_data_next  = fifo_head;
          tx_valid_next = 1'b1;
          state_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next   = ST_GAP;
            gap_cnt_next = CW'(GAP_CYCLES - 1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      // All-ones so a button held through reset is not seen as a press.
      btn_q_reg      <= '1;
      sw_q_reg       <= 1'b0;
      pend_op_reg    <= '0;
      pend_start_reg <= 1'b0;
      pend_stop_reg  <= 1'b0;
      state_reg      <= ST_IDLE;
      gap_cnt_reg    <= '0;
      tx_data_reg    <= 8'h00;
      tx_valid_reg   <= 1'b0;
    end else begin
      btn_q_reg      <= btn;
      sw_q_reg       <= sw_start;
      pend_op_reg    <= pend_op_next;
      pend_start_reg <= pend_start_next;
      pend_stop_reg  <= pend_stop_next;
      state_reg      <= state_next;
      gap_cnt_reg    <= gap_cnt_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
    end
  end

  assign tx_data    = tx_data_reg;
  assign tx_valid   = tx_valid_reg;
  assign queue_full = fifo_full;
  assign busy_led   = (fifo_count != '0) | (state_reg != ST_IDLE);

endmodule

// File: tb/tb_send_operate_data.sv
// tb_send_operate_data: drives two packers (gap 8 and gap 0) with the same
// stimulus and checks both against a time-stamp/queue reference model.
module tb_send_operate_data;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic       sw;
  logic       tx_ready;
  logic [7:0] txd [2];
  logic       txv [2];
  logic       qf  [2];
  logic       bl  [2];

  always #5 clk = ~clk;

  send_operate_data #(.DEPTH(DEPTH), .GAP_CYCLES(8)) dut_gap (
    .uart_clk(clk), .rst(rst), .btn(btn), .sw_start(sw), .tx_ready(tx_ready),
    .tx_data(txd[0]), .tx_valid(txv[0]), .queue_full(qf[0]), .busy_led(bl[0]));

  send_operate_data #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut_nogap (
    .uart_clk(clk), .rst(rst), .btn(btn), .sw_start(sw), .tx_ready(tx_ready),
    .tx_data(txd[1]), .tx_valid(txv[1]), .queue_full(qf[1]), .busy_led(bl[1]));

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         t = 0;
  logic [7:0] mq [2][DEPTH];
  int         mn [2];
  logic       m_send [2];
  logic [7:0] m_cur [2];
  int         m_gap_end [2];
  logic [4:0] m_ops [2];
  logic       m_pstart [2];
  logic       m_pstop [2];
  logic [4:0] prev_btn;
  logic       prev_sw;
  logic [7:0] op_tab [5];

  // Bytes observed crossing the DUT handshake
  logic [7:0] lg [2][128];
  int         lt [2][128];
  int         ln [2];
  logic       obs_v [2];
  logic [7:0] obs_d [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; m_send[k] = 1'b0; m_cur[k] = 8'h00; m_gap_end[k] = -1;
      m_ops[k] = '0; m_pstart[k] = 1'b0; m_pstop[k] = 1'b0;
    end
    prev_btn = 5'b11111;
    prev_sw  = 1'b0;
  endtask

  task automatic clear_log();
    ln[0] = 0; ln[1] = 0;
  endtask

  // One clock edge of the model: inputs are the values present at the edge.
  task automatic model_edge();
    logic [4:0] rise;
    logic srise, sfall;
    t++;
    rise  = btn & ~prev_btn;
    srise = sw & ~prev_sw;
    sfall = ~sw & prev_sw;
    for (int k = 0; k < 2; k++) begin
      logic acc, pp, any, wr;
      logic [7:0] wb;
      int src;
      acc = m_send[k] && tx_ready;
      pp  = !m_send[k] && (t > m_gap_end[k]) && (mn[k] > 0);
      any = m_pstart[k] || m_pstop[k] || (m_ops[k] != 5'b0);
      wr  = any && ((mn[k] < DEPTH) || pp);
      wb  = 8'h00;
      src = 0;
      if (m_pstart[k]) wb = 8'h04;
      else if (m_pstop[k]) wb = 8'h08;
      else begin
        for (int i = 4; i >= 0; i--) begin
          if (m_ops[k][i]) begin wb = op_tab[i]; src = i; end
        end
      end
      if (acc) begin
        m_send[k] = 1'b0;
        m_gap_end[k] = t + gap_of(k);
      end
      if (pp) begin
        m_cur[k] = mq[k][0];
        for (int j = 0; j < DEPTH - 1; j++) mq[k][j] = mq[k][j+1];
        mn[k]--;
        m_send[k] = 1'b1;
      end
      if (wr) begin
        mq[k][mn[k]] = wb;
        mn[k]++;
        if (m_pstart[k]) m_pstart[k] = 1'b0;
        else if (m_pstop[k]) m_pstop[k] = 1'b0;
        else m_ops[k][src] = 1'b0;
      end
      m_ops[k] = m_ops[k] | rise;
      if (srise) begin m_pstart[k] = 1'b1; m_pstop[k] = 1'b0; end
      else if (sfall) begin m_pstop[k] = 1'b1; m_pstart[k] = 1'b0; end
    end
    prev_btn = btn;
    prev_sw  = sw;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (obs_v[k] && tx_ready) begin
          if (ln[k] < 128) begin
            lg[k][ln[k]] = obs_d[k];
            lt[k][ln[k]] = t + 1;
          end
          ln[k]++;
        end
      end
      model_edge();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tx_valid[%0d]", k), 32'(txv[k]), 32'(m_send[k]));
      chk($sformatf("tx_data[%0d]", k), 32'(txd[k]), 32'(m_cur[k]));
      chk($sformatf("queue_full[%0d]", k), 32'(qf[k]), 32'(mn[k] == DEPTH));
      chk($sformatf("busy_led[%0d]", k), 32'(bl[k]),
          32'((mn[k] > 0) || m_send[k] || (t < m_gap_end[k])));
      obs_v[k] = txv[k];
      obs_d[k] = txd[k];
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int n);
    #2 rst = 1'b1;
    model_reset();
    run(n);
    rst = 1'b0;
  endtask

  initial begin
    int t0, n04, n08;
    op_tab = '{8'h05, 8'h09, 8'h0D, 8'h11, 8'h15};
    rst = 1'b1; btn = 5'b0; sw = 1'b0; tx_ready = 1'b1;
    obs_v[0] = 1'b0; obs_v[1] = 1'b0;
    model_reset();
    clear_log();

    // Reset state, then let btn_q settle to the idle buttons
    run(3);
    rst = 1'b0;
    run(2);

    // Single press of throw, 2-cycle latency then one byte
    clear_log();
    t0 = t + 1;
    btn = 5'b10000; run(3);
    btn = 5'b00000; run(20);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("single_count[%0d]", k), 32'(ln[k]), 32'd1);
      chk($sformatf("single_byte[%0d]", k), 32'(lg[k][0]), 32'h15);
      chk($sformatf("single_accept_edge[%0d]", k), 32'(lt[k][0]), 32'(t0 + 3));
      chk($sformatf("single_busy_end[%0d]", k), 32'(bl[k]), 32'd0);
    end

    // Simultaneous get + interact
    clear_log();
    btn = 5'b00101; run(1);
    btn = 5'b00000; run(30);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("simul_count[%0d]", k), 32'(ln[k]), 32'd2);
      chk($sformatf("simul_first[%0d]", k), 32'(lg[k][0]), 32'h05);
      chk($sformatf("simul_second[%0d]", k), 32'(lg[k][1]), 32'h0D);
      chk($sformatf("simul_spacing[%0d]", k), 32'(lt[k][1] - lt[k][0]), 32'(2 + gap_of(k)));
    end

    // Backpressure with all five buttons: one byte held, FIFO full
    clear_log();
    tx_ready = 1'b0;
    btn = 5'b11111; run(2);
    btn = 5'b00000; run(8);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bp_held_data[%0d]", k), 32'(txd[k]), 32'h05);
      chk($sformatf("bp_full[%0d]", k), 32'(qf[k]), 32'd1);
    end
    tx_ready = 1'b1; run(70);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bp_count[%0d]", k), 32'(ln[k]), 32'd5);
      for (int i = 0; i < 5; i++)
        chk($sformatf("bp_byte%0d[%0d]", i, k), 32'(lg[k][i]), 32'(op_tab[i]));
    end

    // START has priority over a same-cycle put
    clear_log();
    btn = 5'b00010; sw = 1'b1; run(1);
    btn = 5'b00000; run(30);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("prio_count[%0d]", k), 32'(ln[k]), 32'd2);
      chk($sformatf("prio_first[%0d]", k), 32'(lg[k][0]), 32'h04);
      chk($sformatf("prio_second[%0d]", k), 32'(lg[k][1]), 32'h09);
    end

    // Switch 1->0->1 while the FIFO is full collapses to a single START
    clear_log();
    tx_ready = 1'b0;
    btn = 5'b11111; run(2);
    btn = 5'b00000; run(8);
    sw = 1'b0; run(1);
    sw = 1'b1; run(5);
    tx_ready = 1'b1; run(90);
    for (int k = 0; k < 2; k++) begin
      n04 = 0; n08 = 0;
      for (int i = 0; i < ln[k] && i < 128; i++) begin
        if (lg[k][i] == 8'h04) n04++;
        if (lg[k][i] == 8'h08) n08++;
      end
      chk($sformatf("lew_count[%0d]", k), 32'(ln[k]), 32'd6);
      chk($sformatf("lew_starts[%0d]", k), 32'(n04), 32'd1);
      chk($sformatf("lew_stops[%0d]", k), 32'(n08), 32'd0);
      chk($sformatf("lew_last[%0d]", k), 32'(lg[k][5]), 32'h04);
    end

    // Button held through reset produces nothing
    sw = 1'b0; run(30);
    clear_log();
    btn = 5'b01000;
    do_reset(3);
    run(20);
    for (int k = 0; k < 2; k++)
      chk($sformatf("held_rst_count[%0d]", k), 32'(ln[k]), 32'd0);

    // Reset in SEND abandons the byte immediately; START follows release
    btn = 5'b00000; tx_ready = 1'b0; run(1);
    btn = 5'b00001; run(1);
    btn = 5'b00000; run(4);
    for (int k = 0; k < 2; k++)
      chk($sformatf("pre_rst_valid[%0d]", k), 32'(txv[k]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_valid[%0d]", k), 32'(txv[k]), 32'd0);
      chk($sformatf("async_busy[%0d]", k), 32'(bl[k]), 32'd0);
    end
    model_reset();
    sw = 1'b1;
    run(2);
    rst = 1'b0;
    tx_ready = 1'b1;
    run(20);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_start_count[%0d]", k), 32'(ln[k]), 32'd1);
      chk($sformatf("rst_start_byte[%0d]", k), 32'(lg[k][0]), 32'h04);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(7) == 0) btn[i] = ~btn[i];
      if ($urandom_range(19) == 0) sw = ~sw;
      tx_ready = ($urandom_range(9) < 7);
      if (c % 500 == 499) begin
        do_reset(2);
      end
      run(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
